// File: rtl/alu_pkg.sv
// Shared types for the ALU and its two-requester sharing controller:
// opcodes, sequencer states, flag layout and the illegal-opcode check.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_XOR = 3'd1,
      OP_SUB = 3'd2,
      OP_SLT = 3'd3,
      OP_SLL = 3'd4,
      OP_SRL = 3'd5
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic gt;
      logic negative;
      logic overflow;
      logic zero;
      logic carry;
   } alu_flags_t;

   localparam logic [2:0] ALU_OP_LAST = 3'd5;

   function automatic logic isIllegalOp(input logic [2:0] op);
      return (op > ALU_OP_LAST);
   endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU: add, xor, sub, unsigned slt, sll, srl.
// Flags are produced for add/sub only (gt for sub only) and are 0 otherwise.
module alu
   import alu_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [2:0]  ALUControl,
   output logic [31:0] o_result,
   output alu_flags_t  o_flags
);

   logic [32:0] w_sum;
   logic [32:0] w_diff;
   logic [4:0]  w_shamt;

   // Subtraction as a + ~b + 1, so the carry out means "no borrow" (a >= b unsigned).
   assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff  = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
   assign w_shamt = i_b[10:6];

   always_comb begin
      o_result = 32'd0;
      o_flags  = '0;
      case (ALUControl)
         OP_ADD: begin
            o_result         = w_sum[31:0];
            o_flags.carry    = w_sum[32];
            o_flags.zero     = (w_sum[31:0] == 32'd0);
            o_flags.overflow = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            o_flags.negative = w_sum[31];
         end
         OP_XOR: o_result = i_a ^ i_b;
         OP_SUB: begin
            o_result         = w_diff[31:0];
            o_flags.carry    = w_diff[32];
            o_flags.zero     = (w_diff[31:0] == 32'd0);
            o_flags.overflow = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
            o_flags.negative = w_diff[31];
            // Signed greater-than: result non-zero and N == V.
            o_flags.gt       = (w_diff[31:0] != 32'd0) &&
                               (w_diff[31] == ((i_a[31] != i_b[31]) && (w_diff[31] != i_a[31])));
         end
         OP_SLT: o_result = {31'd0, (i_a < i_b)};
         OP_SLL: o_result = i_a << w_shamt;
         OP_SRL: o_result = i_a >> w_shamt;
         default: begin
            o_result = 32'd0;
            o_flags  = '0;
         end
      endcase
   end

endmodule

// File: rtl/rr_arbiter2.sv
// Combinational two-way grant: the pointed-to requester wins if valid,
// otherwise the other one. The pointer itself is kept by the parent.
module rr_arbiter2 (
   input  logic [1:0] i_valid,
   input  logic       i_prio,
   output logic [1:0] o_grant,
   output logic       o_grantIdx
);

   logic w_other;

   assign w_other = ~i_prio;

   always_comb begin
      o_grant    = 2'b00;
      o_grantIdx = i_prio;
      if (i_valid[i_prio]) begin
         o_grant[i_prio] = 1'b1;
         o_grantIdx      = i_prio;
      end else if (i_valid[w_other]) begin
         o_grant[w_other] = 1'b1;
         o_grantIdx       = w_other;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters with round-robin priority and an
// IDLE -> EXEC -> RESP sequencer; one operation in flight at a time.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int NREQ = 2
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0][31:0] req_a,
   input  logic [NREQ-1:0][31:0] req_b,
   input  logic [NREQ-1:0][2:0] req_op,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [31:0]          rsp_data,
   output logic [4:0]           rsp_flags,
   output logic                 rsp_err
);

   generate
      if (NREQ != 2) begin : g_nreqCheck
         $error("alu_share_ctrl supports exactly two requesters");
      end
   endgenerate

   ctrl_state_t r_state;
   ctrl_state_t w_nextState;
   logic        r_prio;
   logic        r_owner;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [2:0]  r_op;
   logic [31:0] r_rspData;
   alu_flags_t  r_rspFlags;
   logic        r_rspErr;

   logic [1:0]  w_grant;
   logic        w_grantIdx;
   logic        w_accept;
   logic        w_illegal;
   logic [2:0]  w_aluOp;
   logic [31:0] w_aluResult;
   alu_flags_t  w_aluFlags;

   rr_arbiter2 u_arb (
      .i_valid    (req_valid),
      .i_prio     (r_prio),
      .o_grant    (w_grant),
      .o_grantIdx (w_grantIdx)
   );

   // Illegal opcodes never reach the ALU; it sees add so its outputs stay defined.
   assign w_illegal = isIllegalOp(r_op);
   assign w_aluOp   = w_illegal ? 3'd0 : r_op;

   alu u_alu (
      .i_a        (r_a),
      .i_b        (r_b),
      .ALUControl (w_aluOp),
      .o_result   (w_aluResult),
      .o_flags    (w_aluFlags)
   );

   assign w_accept = (r_state == IDLE) && (|req_valid) && !rst;

   always_comb begin
      w_nextState = r_state;
      req_ready   = '0;
      rsp_valid   = '0;
      case (r_state)
         IDLE: begin
            req_ready = w_grant;
            if (|req_valid) begin
               w_nextState = EXEC;
            end
         end
         EXEC: begin
            w_nextState = RESP;
         end
         RESP: begin
            rsp_valid[r_owner] = 1'b1;
            if (rsp_ready[r_owner]) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
      // Reset wins over any handshake, so nothing is shown as accepted or offered.
      if (rst) begin
         req_ready = '0;
         rsp_valid = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_prio     <= 1'b0;
         r_owner    <= 1'b0;
         r_a        <= 32'd0;
         r_b        <= 32'd0;
         r_op       <= 3'd0;
         r_rspData  <= 32'd0;
         r_rspFlags <= '0;
         r_rspErr   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_a     <= req_a[w_grantIdx];
            r_b     <= req_b[w_grantIdx];
            r_op    <= req_op[w_grantIdx];
            r_owner <= w_grantIdx;
            r_prio  <= ~w_grantIdx;
         end
         if (r_state == EXEC) begin
            if (w_illegal) begin
               r_rspData  <= 32'd0;
               r_rspFlags <= '0;
               r_rspErr   <= 1'b1;
            end else begin
               r_rspData  <= w_aluResult;
               r_rspFlags <= w_aluFlags;
               r_rspErr   <= 1'b0;
            end
         end
      end
   end

   assign rsp_data  = r_rspData;
   assign rsp_flags = r_rspFlags;
   assign rsp_err   = r_rspErr;

endmodule
